act_c2_fifo_mux: RTL and testbench

// - Registered, elastic successor to the ACT C2 combinational cell.
// - Same 4:1 select law: S1 = A1|B1, S0 = A0&B0; selects D00/D01/D10/D11 by {S1,S0}.
// - Each accepted selection is pushed into a DEPTH-entry FIFO and drained through a valid/ready port.
// - Sits between ACT-cell datapaths and downstream consumers that can stall.

---
 rtl/act_c2_fifo_mux.sv | 168 ++++++++++++++++
 tb/tb_act_c2_fifo_mux.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/act_c2_fifo_mux.sv
// act_c2_fifo_mux: ACT C2 4:1 select cell feeding an elastic FIFO drained through valid/ready.
// Latency: a selection pushed at edge k appears on out_data/out_valid after edge k; never combinational in->out.
// Backpressure: in_ready drops while DEPTH entries are held; no pass-through when full, even with a same-cycle pop.
// Optional macro ACT_SEL_TAG_EN stores {S1,S0} with each entry and exposes it on out_sel.

// act_c2_fifo: generic DEPTH-entry FIFO (any DEPTH >= 1, not only powers of two).
// Latency: one cycle from write to read-side visibility; read data is a registered head entry.
// Backpressure: wr_rdy = not full (a pop in the same cycle does not free a slot); rd_dat is 0 while empty.
module act_c2_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_vld,
  output logic          wr_rdy,
  input  logic [W-1:0]  wr_dat,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic [W-1:0]  rd_dat,
  output logic [CW-1:0] count
);

  // Pointer width stays at least 1 so DEPTH=1 still has a legal (constant-zero) pointer.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push;
  logic          pop;

  // Handshake flags and head-entry presentation, all decoded from registered state.
  always_comb begin
    wr_rdy = (cnt_q != CNT_FULL);
    rd_vld = (cnt_q != '0);
    push   = wr_vld & wr_rdy;
    pop    = rd_vld & rd_rdy;
    rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;
    count  = cnt_q;
  end

  // Next-state: storage write, wrapping pointers and occupancy update.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset discards every entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// act_c2_fifo_mux: {S1,S0} = {A1|B1, A0&B0} picks D00/D01/D10/D11; each accepted pick is queued.
// Latency: one cycle from push edge to out_data/out_valid.
// Backpressure: in_ready = (count != DEPTH); out_data holds steady while out_valid & !out_ready.
module act_c2_fifo_mux #(
  parameter int BITS  = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] D00,
  input  logic [BITS-1:0] D01,
  input  logic [BITS-1:0] D10,
  input  logic [BITS-1:0] D11,
  input  logic            A1,
  input  logic            B1,
  input  logic            A0,
  input  logic            B0,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
`ifdef ACT_SEL_TAG_EN
  output logic [1:0]      out_sel,
`endif
  output logic [CW-1:0]   count
);

`ifdef ACT_SEL_TAG_EN
  localparam int EW = BITS + 2;
`else
  localparam int EW = BITS;
`endif

  logic [1:0]      sel;
  logic [BITS-1:0] mux_dat;
  logic [EW-1:0]   wr_ent;
  logic [EW-1:0]   rd_ent;

  // C2 select law and 4:1 data pick, evaluated combinationally for the push edge.
  always_comb begin
    sel = {A1 | B1, A0 & B0};
    case (sel)
      2'b00:   mux_dat = D00;
      2'b01:   mux_dat = D01;
      2'b10:   mux_dat = D10;
      default: mux_dat = D11;
    endcase
  end

  // Entry packing: the select code rides along in the upper bits when tagging is enabled.
  always_comb begin
`ifdef ACT_SEL_TAG_EN
    wr_ent = {sel, mux_dat};
`else
    wr_ent = mux_dat;
`endif
  end

  act_c2_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (in_valid),
    .wr_rdy (in_ready),
    .wr_dat (wr_ent),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (rd_ent),
    .count  (count)
  );

  // Head entry unpacking; the FIFO already forces zero when empty, so out_sel is 00 then too.
  always_comb begin
    out_data = rd_ent[BITS-1:0];
`ifdef ACT_SEL_TAG_EN
    out_sel  = rd_ent[BITS+1:BITS];
`endif
  end

endmodule

// File: tb/tb_act_c2_fifo_mux.sv
// Directed bench for act_c2_fifo_mux (BITS=8, DEPTH=4): select law, fill/full, push+pop across
// pointer wrap, backpressure hold and mid-operation reset, all against hand-computed constants.
module tb_act_c2_fifo_mux;

  logic       clk;
  logic       rst_n;
  logic [7:0] D00, D01, D10, D11;
  logic       A1, B1, A0, B0;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;
`ifdef ACT_SEL_TAG_EN
  logic [1:0] out_sel;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  act_c2_fifo_mux #(.BITS(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .D00       (D00),
    .D01       (D01),
    .D10       (D10),
    .D11       (D11),
    .A1        (A1),
    .B1        (B1),
    .A0        (A0),
    .B0        (B0),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef ACT_SEL_TAG_EN
    .out_sel   (out_sel),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; all checks happen 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer value v through the D00 leg (all select terms low).
  task automatic offer(input logic [7:0] v);
    {A1, B1, A0, B0} = 4'b0000;
    D00 = v;
    in_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    D00 = 8'h00; D01 = 8'h00; D10 = 8'h00; D11 = 8'h00;
    {A1, B1, A0, B0} = 4'b0000;
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_count", count, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_data", out_data, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;

    // Select law: each push visible one cycle later, drained immediately
    D00 = 8'h11; D01 = 8'h22; D10 = 8'h33; D11 = 8'h44;
    out_ready = 1'b1;
    in_valid = 1'b1;
    {A1, B1, A0, B0} = 4'b0000;
    tick();
    check_eq("sel00_data", out_data, 8'h11);
    check_eq("sel00_valid", out_valid, 1);
`ifdef ACT_SEL_TAG_EN
    check_eq("sel00_tag", out_sel, 2'b00);
`endif
    {A1, B1, A0, B0} = 4'b0011;
    tick();
    check_eq("sel01_data", out_data, 8'h22);
    check_eq("sel01_count", count, 1);
`ifdef ACT_SEL_TAG_EN
    check_eq("sel01_tag", out_sel, 2'b01);
`endif
    {A1, B1, A0, B0} = 4'b1000;
    tick();
    check_eq("sel10_data", out_data, 8'h33);
`ifdef ACT_SEL_TAG_EN
    check_eq("sel10_tag", out_sel, 2'b10);
`endif
    {A1, B1, A0, B0} = 4'b0111;
    tick();
    check_eq("sel11_data", out_data, 8'h44);
`ifdef ACT_SEL_TAG_EN
    check_eq("sel11_tag", out_sel, 2'b11);
`endif
    in_valid = 1'b0;
    tick();
    check_eq("drain_valid", out_valid, 0);
    check_eq("drain_data", out_data, 8'h00);
    check_eq("drain_count", count, 0);
`ifdef ACT_SEL_TAG_EN
    check_eq("drain_tag", out_sel, 2'b00);
`endif

    // Fill/full: five offers with out_ready low, only four accepted
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      offer(8'(i));
      tick();
      if (i == 4) begin
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_count", count, 4);
      end
    end
    check_eq("full_count_after5", count, 4);
    check_eq("full_head", out_data, 8'h01);
    // Pop while full and still offering: pop only
    offer(8'h06);
    out_ready = 1'b1;
    tick();
    check_eq("fullpop_count", count, 3);
    check_eq("fullpop_head", out_data, 8'h02);
    check_eq("fullpop_in_ready", in_ready, 1);

    // Bring occupancy to 2 (contents 3,4)
    in_valid = 1'b0;
    tick();
    check_eq("pre_sim_count", count, 2);
    check_eq("pre_sim_head", out_data, 8'h03);

    // Simultaneous push+pop for 10 cycles across pointer wrap
    for (int i = 0; i < 10; i++) begin
      offer(8'(8'h10 + i));
      out_ready = 1'b1;
      tick();
      check_eq($sformatf("sim_count_%0d", i), count, 2);
      check_eq($sformatf("sim_head_%0d", i), out_data, (i == 0) ? 8'h04 : 8'(8'h10 + i - 1));
    end

    // Backpressure hold: contents 0x18,0x19; inputs wiggle but are not pushed
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      D00 = 8'($urandom);
      D11 = 8'($urandom);
      {A1, B1, A0, B0} = 4'($urandom);
      tick();
      check_eq($sformatf("hold_data_%0d", i), out_data, 8'h18);
      check_eq($sformatf("hold_valid_%0d", i), out_valid, 1);
    end
    check_eq("hold_count", count, 2);

    // Reset mid-operation with three entries held
    offer(8'h20);
    tick();
    check_eq("premid_count", count, 3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_count", count, 0);
    check_eq("midrst_data", out_data, 8'h00);
    tick();
    tick();
    check_eq("midrst_hold_count", count, 0);
    rst_n = 1'b1;
    out_ready = 1'b0;
    offer(8'h55);
    tick();
    in_valid = 1'b0;
    check_eq("post_rst_count", count, 1);
    check_eq("post_rst_data", out_data, 8'h55);
    check_eq("post_rst_valid", out_valid, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
